// File: rtl/round_robin_arbiter_if.sv
// round_robin_arbiter_if: request/release/grant bundle between requesters and the arbiter
interface round_robin_arbiter_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] requests;
  logic             release_grant;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  modport master (output requests, release_grant, input grant, grant_valid);
  modport slave (input requests, release_grant, output grant, grant_valid);
endinterface

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered one-hot round-robin arbiter; define ARB_BACK_TO_BACK_EN for bubble-free regrant on release
module round_robin_arbiter #(
  parameter int WIDTH = 16
) (
  input logic clock,
  input logic reset,
  round_robin_arbiter_if.slave arb
);
  localparam int PW = $clog2(WIDTH);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt, idx, base, win, j;
  logic [WIDTH-1:0] grant_q, grant_nxt;
  logic valid_q, hit;
  // binary index of the currently held grant
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      idx = grant_q[i] ? PW'(i) : idx;
  end
  // search start: the post-release pointer lets a back-to-back regrant skip the releasing requester
  always_comb begin
`ifdef ARB_BACK_TO_BACK_EN
    base = (state == GRANTED && arb.release_grant) ? idx + 1'b1 : ptr;
`else
    base = ptr;
`endif
  end
  // first requester at or after base, wrapping modulo WIDTH
  always_comb begin
    hit = 1'b0;
    win = '0;
    j = '0;
    for (int k = 0; k < WIDTH; k++) begin
      j = base + PW'(k);
      if (!hit && arb.requests[j]) begin
        hit = 1'b1;
        win = j;
      end
    end
  end
  // next-state, pointer and grant decisions
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    grant_nxt = grant_q;
    if (state == IDLE) begin
      state_nxt = hit ? GRANTED : IDLE;
      grant_nxt = hit ? WIDTH'(1) << win : '0;
    end else if (arb.release_grant) begin
      ptr_nxt = idx + 1'b1;
`ifdef ARB_BACK_TO_BACK_EN
      state_nxt = hit ? GRANTED : IDLE;
      grant_nxt = hit ? WIDTH'(1) << win : '0;
`else
      state_nxt = IDLE;
      grant_nxt = '0;
`endif
    end
  end
  // state, pointer and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      grant_q <= grant_nxt;
      valid_q <= |grant_nxt;
    end
  end
  assign arb.grant = grant_q;
  assign arb.grant_valid = valid_q;
endmodule
